// File: rtl/paddle_scan_ctrl.sv
// Periodic paddle scanner: snapshots the enabled channels on every period tick and
// runs each one through the shared scaler. Optional WAIT timeout under PADDLE_SCAN_TIMEOUT_EN.
module paddle_scan_ctrl #(
    parameter int PERIOD  = 512,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      mask,
    input  logic [3:0][7:0] pd_in,
    output logic            sc_req,
    output logic [1:0]      sc_ch,
    output logic [7:0]      sc_value,
    input  logic            sc_ack,
    input  logic [7:0]      sc_result,
    output logic [3:0][7:0] pot_out,
    output logic            pot_valid,
    output logic            busy,
    output logic            overrun,
    output logic [3:0]      timeout_err,
    output logic [2:0]      o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_cnt;
    logic            w_tick;
    logic [3:0]      r_mask;
    logic [3:0][7:0] r_snap;
    logic [1:0]      r_ch;
    logic [7:0]      r_result;
    logic            r_skip;
    logic [3:0][7:0] r_pot;
    logic            r_ovr;
    logic [1:0]      w_first_ch;
    logic [1:0]      w_next_ch;
    logic            w_next_found;
    logic            w_timeout;

    // Free-running period counter; the tick is the cycle whose edge wraps it to 0.
    assign w_tick = (r_cnt == 16'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
        end else if (w_tick) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_first_ch   = 2'd0;
        w_next_ch    = 2'd0;
        w_next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                w_first_ch = 2'(i);
            end
            if (r_mask[i] && (3'(i) > {1'b0, r_ch})) begin
                w_next_ch    = 2'(i);
                w_next_found = 1'b1;
            end
        end
    end

`ifdef PADDLE_SCAN_TIMEOUT_EN
    logic [7:0] r_wcnt;
    logic [3:0] r_terr;

    assign w_timeout = (r_state == S_WAIT) && !sc_ack && (r_wcnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt <= 8'd0;
            r_terr <= 4'd0;
        end else begin
            r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 8'd1 : 8'd0;
            if (w_timeout) begin
                r_terr[r_ch] <= 1'b1;
            end
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 4'd0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_tick && (mask != 4'd0)) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (sc_ack || w_timeout) w_next_state = S_STORE;
            S_STORE: w_next_state = w_next_found ? S_ISSUE : S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Scan datapath; r_skip marks a channel that timed out so STORE leaves pot_out alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= 4'd0;
            r_snap   <= '0;
            r_ch     <= 2'd0;
            r_result <= 8'd0;
            r_skip   <= 1'b0;
            r_pot    <= {4{8'h80}};
            r_ovr    <= 1'b0;
        end else begin
            r_ovr <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick && (mask != 4'd0)) begin
                        r_mask <= mask;
                        r_snap <= pd_in;
                        r_ch   <= w_first_ch;
                    end
                end
                S_WAIT: begin
                    if (sc_ack) begin
                        r_result <= sc_result;
                        r_skip   <= 1'b0;
                    end else if (w_timeout) begin
                        r_skip <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (!r_skip) begin
                        r_pot[r_ch] <= r_result;
                    end
                    if (w_next_found) begin
                        r_ch <= w_next_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sc_req      = (r_state == S_ISSUE) || (r_state == S_WAIT);
        sc_ch       = r_ch;
        sc_value    = r_snap[r_ch];
        busy        = (r_state != S_IDLE);
        pot_valid   = (r_state == S_DONE);
        pot_out     = r_pot;
        overrun     = r_ovr;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_paddle_scan_ctrl.sv
// Directed bench for paddle_scan_ctrl with PERIOD=16; the timeout case runs only when
// PADDLE_SCAN_TIMEOUT_EN is defined.
module tb_paddle_scan_ctrl;
    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      mask;
    logic [3:0][7:0] pd_in;
    logic            sc_req;
    logic [1:0]      sc_ch;
    logic [7:0]      sc_value;
    logic            sc_ack;
    logic [7:0]      sc_result;
    logic [3:0][7:0] pot_out;
    logic            pot_valid;
    logic            busy;
    logic            overrun;
    logic [3:0]      timeout_err;
    logic [2:0]      dbg_state;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ovr = 0;
    int base_v;
    int base_o;
    logic ok;

    paddle_scan_ctrl #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .mask(mask), .pd_in(pd_in),
        .sc_req(sc_req), .sc_ch(sc_ch), .sc_value(sc_value),
        .sc_ack(sc_ack), .sc_result(sc_result), .pot_out(pot_out),
        .pot_valid(pot_valid), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (pot_valid) n_valid++;
            if (overrun) n_ovr++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max);
        int k;
        k = 0;
        while (!sc_req && k < max) begin
            step();
            k++;
        end
        check("req_seen", 32'(sc_req), 32'd1);
    endtask

    initial begin
        mask      = 4'b0101;
        pd_in     = {8'h44, 8'h20, 8'h33, 8'h10};
        sc_ack    = 1'b0;
        sc_result = 8'h00;
        #12;
        check("rst_pot0", 32'(pot_out[0]), 32'h80);
        check("rst_pot1", 32'(pot_out[1]), 32'h80);
        check("rst_pot2", 32'(pot_out[2]), 32'h80);
        check("rst_pot3", 32'(pot_out[3]), 32'h80);
        check("rst_req", 32'(sc_req), 32'd0);
        check("rst_ch", 32'(sc_ch), 32'd0);
        check("rst_value", 32'(sc_value), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(pot_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic two-channel scan, scaler answers value+1 the cycle after the request.
        repeat (PERIOD - 1) step();
        check("pre_tick_busy", 32'(busy), 32'd0);
        step();
        check("tick_req", 32'(sc_req), 32'd1);
        check("ch0_sel", 32'(sc_ch), 32'd0);
        check("ch0_value", 32'(sc_value), 32'h10);
        check("scan_busy", 32'(busy), 32'd1);
        base_v = n_valid;
        step();
        sc_ack = 1'b1; sc_result = 8'h11;
        step();
        sc_ack = 1'b0;
        check("store_req_low", 32'(sc_req), 32'd0);
        step();
        check("pot0_written", 32'(pot_out[0]), 32'h11);
        check("ch2_sel", 32'(sc_ch), 32'd2);
        check("ch2_value", 32'(sc_value), 32'h20);
        check("ch2_req", 32'(sc_req), 32'd1);
        step();
        sc_ack = 1'b1; sc_result = 8'h21;
        step();
        sc_ack = 1'b0;
        step();
        check("done_valid", 32'(pot_valid), 32'd1);
        check("pot2_written", 32'(pot_out[2]), 32'h21);
        step();
        check("idle_valid", 32'(pot_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("pot1_hold", 32'(pot_out[1]), 32'h80);
        check("pot3_hold", 32'(pot_out[3]), 32'h80);
        check("one_valid", 32'(n_valid - base_v), 32'd1);

        // Input changes mid-scan are ignored until the next scan.
        mask = 4'b0001;
        wait_req(40);
        check("snap_value", 32'(sc_value), 32'h10);
        step();
        pd_in[0] = 8'hF0;
        mask     = 4'b1111;
        repeat (3) begin
            step();
            check("hold_value", 32'(sc_value), 32'h10);
        end
        sc_ack = 1'b1; sc_result = 8'h5A;
        step();
        sc_ack = 1'b0;
        step();
        check("snap_mask_done", 32'(pot_valid), 32'd1);
        step();
        check("pot0_5a", 32'(pot_out[0]), 32'h5A);
        mask = 4'b0001;
        wait_req(40);
        check("next_scan_value", 32'(sc_value), 32'hF0);
        step();
        sc_ack = 1'b1; sc_result = 8'hF1;
        step();
        sc_ack = 1'b0;
        step();
        step();
        check("pot0_f1", 32'(pot_out[0]), 32'hF1);

`ifndef PADDLE_SCAN_TIMEOUT_EN
        // Ack held off 40 cycles: two ticks dropped, request held stable.
        base_o = n_ovr;
        base_v = n_valid;
        wait_req(40);
        step();
        ok = 1'b1;
        repeat (39) begin
            step();
            if (!(sc_req === 1'b1 && sc_value === 8'hF0 && busy === 1'b1)) ok = 1'b0;
        end
        check("req_stable", 32'(ok), 32'd1);
        sc_ack = 1'b1; sc_result = 8'hAB;
        step();
        sc_ack = 1'b0;
        step();
        check("slow_done", 32'(pot_valid), 32'd1);
        step();
        check("pot0_ab", 32'(pot_out[0]), 32'hAB);
        check("overrun_cnt", 32'(n_ovr - base_o), 32'd2);
        check("slow_one_valid", 32'(n_valid - base_v), 32'd1);
`endif
        mask = 4'b0000;

        // No channels enabled for three periods.
        base_v = n_valid;
        ok = 1'b1;
        repeat (3 * PERIOD + 4) begin
            step();
            if (sc_req !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("mask0_idle", 32'(ok), 32'd1);
        check("mask0_no_valid", 32'(n_valid - base_v), 32'd0);

        // Asynchronous reset in the middle of WAIT.
        mask = 4'b0001;
        wait_req(40);
        step();
        base_v = n_valid;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", 32'(sc_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pot0", 32'(pot_out[0]), 32'h80);
        check("arst_pot2", 32'(pot_out[2]), 32'h80);
        check("arst_ch", 32'(sc_ch), 32'd0);
        check("arst_value", 32'(sc_value), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_terr", 32'(timeout_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (PERIOD - 1) step();
        check("rel_pre_tick", 32'(busy), 32'd0);
        check("arst_no_valid", 32'(n_valid - base_v), 32'd0);
        step();
        check("rel_first_tick", 32'(sc_req), 32'd1);
        check("rel_value", 32'(sc_value), 32'hF0);
        step();
        sc_ack = 1'b1; sc_result = 8'h77;
        step();
        sc_ack = 1'b0;
        step();
        step();
        check("pot0_77", 32'(pot_out[0]), 32'h77);

`ifdef PADDLE_SCAN_TIMEOUT_EN
        // Channel 1 never acked: timeout flags it and the scan still completes.
        mask     = 4'b0011;
        pd_in[1] = 8'h33;
        wait_req(40);
        step();
        sc_ack = 1'b1; sc_result = 8'h01;
        step();
        sc_ack = 1'b0;
        step();
        check("tmo_ch1_sel", 32'(sc_ch), 32'd1);
        step();
        repeat (TIMEOUT - 1) step();
        check("tmo_before_err", 32'(timeout_err), 32'd0);
        check("tmo_before_req", 32'(sc_req), 32'd1);
        step();
        check("tmo_err", 32'(timeout_err), 32'b0010);
        check("tmo_req_low", 32'(sc_req), 32'd0);
        step();
        check("tmo_valid", 32'(pot_valid), 32'd1);
        step();
        check("tmo_pot1_hold", 32'(pot_out[1]), 32'h80);
        check("tmo_pot0", 32'(pot_out[0]), 32'h01);
`else
        check("terr_tied", 32'(timeout_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/paddle_scan_ctrl.md
PADDLE_SCAN_CTRL -- requirements
Module: paddle_scan_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 512: clk cycles between scan starts, legal range 16..65535.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum clk cycles to wait for sc_ack, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mask, input, 4 bits: enabled paddle channels.
REQ-006 SHALL have port pd_in, input, 4x8 bits: raw paddle values from the chooser.
REQ-007 SHALL have ports sc_req (output, 1), sc_ch (output, 2) and sc_value (output, 8): the request to the shared scaler.
REQ-008 SHALL have ports sc_ack (input, 1) and sc_result (input, 8): the scaler response.
REQ-009 SHALL have port pot_out, output, 4x8 bits: last scaled value per channel.
REQ-010 SHALL have port pot_valid, output, 1 bit: one-cycle pulse when a scan completes.
REQ-011 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a period tick is dropped.
REQ-013 SHALL have port timeout_err, output, 4 bits: sticky per-channel timeout flags.

Function
REQ-014 SHALL run a free period counter 0..PERIOD-1 and raise an internal tick on the cycle the counter wraps to 0.
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT, STORE and DONE.
REQ-016 IDLE: on tick with mask!=0, SHALL snapshot mask and all pd_in, set ch to the lowest set bit, and go to ISSUE.
REQ-017 IDLE: on tick with mask==0, SHALL stay in IDLE and emit no pot_valid.
REQ-018 ISSUE: SHALL assert sc_req with sc_ch=ch and sc_value=snapshot[ch], then go to WAIT on the next cycle.
REQ-019 sc_req, sc_ch and sc_value SHALL remain stable from ISSUE until the cycle sc_ack is sampled high.
REQ-020 WAIT: on sc_ack high, SHALL capture sc_result and go to STORE; sc_req SHALL be low from the following cycle.
REQ-021 sc_ack SHALL be ignored whenever the block is not in ISSUE or WAIT.
REQ-022 STORE: SHALL write pot_out[ch] and advance ch to the next set bit of the snapshot mask, going to ISSUE; if no set bit remains, it SHALL go to DONE.
REQ-023 DONE: SHALL pulse pot_valid for exactly one cycle, then return to IDLE.
REQ-024 Minimum latency per channel SHALL be 3 cycles: ISSUE, WAIT with ack, STORE.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 A tick arriving while busy SHALL be dropped, SHALL pulse overrun for one cycle, and SHALL leave the scan in progress unchanged.
REQ-027 Changes to mask or pd_in during a scan SHALL have no effect until the next scan.
REQ-028 pot_out of channels masked off SHALL hold their previous value.
REQ-029 The period counter SHALL keep running regardless of state.

Reset
REQ-030 reset_n low SHALL asynchronously force:
- state = IDLE and the period counter = 0
- sc_req = 0, sc_ch = 0, sc_value = 0
- pot_out = 8'h80 for all channels
- pot_valid = 0, busy = 0, overrun = 0, timeout_err = 0
REQ-031 Reset asserted mid-handshake SHALL drop sc_req immediately and discard any pending result.
REQ-032 The first tick after reset release SHALL occur PERIOD cycles after the first clk edge with reset_n high.

Configuration
REQ-033 Macro PADDLE_SCAN_TIMEOUT_EN defined: SHALL count cycles in WAIT, and on reaching TIMEOUT without sc_ack, SHALL:
- set timeout_err[ch]
- drop sc_req
- keep pot_out[ch] unchanged
- continue to the next channel as if through STORE without a write
REQ-034 PADDLE_SCAN_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-035 PERIOD=16, mask=4'b0101, pd_in={..,8'h20,..,8'h10}, scaler acks the cycle after req with value+1: sc_ch sequence 0 then 2; pot_out[0]=8'h11 and pot_out[2]=8'h21; one pot_valid pulse; pot_out[1] and pot_out[3] stay 8'h80.
REQ-036 Ack delayed 40 cycles with PERIOD=16: overrun pulses 2 times; sc_req and sc_value stay stable throughout; the scan completes normally.
REQ-037 With PADDLE_SCAN_TIMEOUT_EN, TIMEOUT=15, ch1 never acked, mask=4'b0011: after 15 WAIT cycles timeout_err=4'b0010; pot_out[1] unchanged; pot_valid still pulses.
REQ-038 Assert reset_n low during WAIT: sc_req goes to 0 without a clock edge; all outputs take their reset values; no pot_valid pulse.
REQ-039 mask=0 for 3 periods: no sc_req, no pot_valid, busy stays 0.
REQ-040 Change pd_in[0] from 8'h10 to 8'hF0 while in WAIT for ch0: sc_value stays 8'h10; the next scan uses 8'hF0.
